// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, ALU op encoding and flag indices
package alu_pkg;

    localparam logic [4:0] ADD   = 5'b00010;
    localparam logic [4:0] ADDI  = 5'b00011;
    localparam logic [4:0] SUB   = 5'b00100;
    localparam logic [4:0] SUBI  = 5'b00101;
    localparam logic [4:0] MUL   = 5'b00110;
    localparam logic [4:0] MOVEH = 5'b00111;
    localparam logic [4:0] DIV   = 5'b01000;
    localparam logic [4:0] AND   = 5'b01010;
    localparam logic [4:0] ANDI  = 5'b01011;
    localparam logic [4:0] OR    = 5'b01100;
    localparam logic [4:0] ORI   = 5'b01101;
    localparam logic [4:0] NOT   = 5'b01110;
    localparam logic [4:0] XOR   = 5'b10000;
    localparam logic [4:0] XORI  = 5'b10001;
    localparam logic [4:0] CMP   = 5'b10010;
    localparam logic [4:0] CALL  = 5'b11001;
    localparam logic [4:0] RET   = 5'b11010;
    localparam logic [4:0] RETI  = 5'b11011;
    localparam logic [4:0] ST    = 5'b11100;
    localparam logic [4:0] LD    = 5'b11101;
    localparam logic [4:0] MOVEL = 5'b11110;

    typedef enum logic [2:0] {
        ADDA = 3'b000,
        SUBA = 3'b001,
        MULA = 3'b010,
        DIVA = 3'b011,
        ANDA = 3'b100,
        ORA  = 3'b101,
        XORA = 3'b110,
        NOTA = 3'b111
    } alu_op_t;

    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational opcode to ALU op mapping
module alu_decode
    import alu_pkg::*;
(
    input  logic [4:0] opcode,
    output alu_op_t    op
);

    // Anything not listed (branches, calls, undefined) falls back to ADDA.
    always_comb begin
        op = ADDA;
        case (opcode)
            ADD, ADDI, ST, LD:         op = ADDA;
            SUB, SUBI, CMP:            op = SUBA;
            MUL:                       op = MULA;
            DIV:                       op = DIVA;
            AND, ANDI, MOVEH, MOVEL:   op = ANDA;
            OR, ORI:                   op = ORA;
            XOR, XORI:                 op = XORA;
            NOT:                       op = NOTA;
            default:                   op = ADDA;
        endcase
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit execute-stage ALU with registered result and N/Z flags
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       opcode,
    output logic [WIDTH-1:0] alu_out,
    output logic [1:0]       flags
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    alu_op_t          op;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             n_flag;
    logic             z_flag;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;

    assign sa = a;
    assign sb = b;

    alu_decode u_decode (
        .opcode (opcode),
        .op     (op)
    );

    // Zero divisor and MIN/-1 are special-cased so the divider never sees them.
    always_comb begin
        result = '0;
        case (op)
            ADDA: result = a + b;
            SUBA: result = a - b;
            MULA: result = sa * sb;
            DIVA: begin
                if (b == '0)
                    result = '0;
                else if (a == MIN_INT && b == '1)
                    result = MIN_INT;
                else
                    result = sa / sb;
            end
            ANDA: result = a & b;
            ORA:  result = a | b;
            XORA: result = a ^ b;
            NOTA: result = ~a;
            default: result = '0;
        endcase
    end

    // For subtraction N is the true signed a<b, corrected for overflow.
    assign ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    assign n_flag = (op == SUBA) ? (result[WIDTH-1] ^ ovf) : result[WIDTH-1];
    assign z_flag = (result == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out <= '0;
            flags   <= 2'b00;
        end else begin
            alu_out        <= result;
            flags[FLAG_N]  <= n_flag;
            flags[FLAG_Z]  <= z_flag;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  opcode;
    logic [31:0] alu_out;
    logic [1:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;

    alu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .opcode  (opcode),
        .alu_out (alu_out),
        .flags   (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, expv);
            $error("check %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic run(input logic [4:0] opc, input logic [31:0] va, input logic [31:0] vb);
        opcode = opc;
        a      = va;
        b      = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] out_exp, input logic [1:0] fl_exp);
        check({tag, ".out"}, alu_out, out_exp);
        check({tag, ".flags"}, {30'd0, flags}, {30'd0, fl_exp});
    endtask

    logic [4:0] dec_opc [0:17];
    logic [2:0] dec_exp [0:17];

    initial begin
        dec_opc = '{5'b00010, 5'b00011, 5'b11101, 5'b11100, 5'b00100, 5'b00101,
                    5'b10010, 5'b00110, 5'b01000, 5'b01010, 5'b01011, 5'b00111,
                    5'b11110, 5'b01100, 5'b01101, 5'b10000, 5'b10001, 5'b01110};
        dec_exp = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1,
                    3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4,
                    3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7};

        rst = 1'b1;
        a = 32'd5; b = 32'd3; opcode = 5'b00010;
        @(posedge clk); #1;
        expect_out("reset", 32'd0, 2'b00);
        rst = 1'b0;
        @(posedge clk); #1;
        expect_out("post_reset_add", 32'd8, 2'b00);

        for (int i = 0; i < 18; i++) begin
            opcode = dec_opc[i];
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("decode_%b", dec_opc[i]), {29'd0, dut.op}, {29'd0, dec_exp[i]});
        end
        opcode = 5'b11001;
        repeat (2) @(posedge clk);
        #1;
        check("decode_call", {29'd0, dut.op}, 32'd0);

        run(5'b00010, 32'hFFFF_FFFF, 32'd1);        expect_out("add_wrap", 32'd0, 2'b01);
        run(5'b00110, 32'hFFFF_FFFD, 32'd7);        expect_out("mul_neg", 32'hFFFF_FFEB, 2'b10);
        run(5'b01000, 32'hFFFF_FFF9, 32'd2);        expect_out("div_trunc", 32'hFFFF_FFFD, 2'b10);
        run(5'b01000, 32'd1234, 32'd0);             expect_out("div_zero", 32'd0, 2'b01);
        run(5'b01000, 32'h8000_0000, 32'hFFFF_FFFF); expect_out("div_ovf", 32'h8000_0000, 2'b10);

        run(5'b10010, 32'd3, 32'd5);                expect_out("cmp_lt", 32'hFFFF_FFFE, 2'b10);
        run(5'b10010, 32'd5, 32'd5);                expect_out("cmp_eq", 32'd0, 2'b01);
        run(5'b10010, 32'h8000_0000, 32'd1);        expect_out("cmp_ovf", 32'h7FFF_FFFF, 2'b10);
        run(5'b00100, 32'd1, 32'hFFFF_FFFF);        expect_out("sub_gt", 32'd2, 2'b00);

        run(5'b01010, 32'hF0F0_F0F0, 32'h0FF0_0FF0); expect_out("and", 32'h00F0_00F0, 2'b00);
        run(5'b01100, 32'hF0F0_F0F0, 32'h0FF0_0FF0); expect_out("or", 32'hFFF0_FFF0, 2'b10);
        run(5'b10000, 32'hF0F0_F0F0, 32'h0FF0_0FF0); expect_out("xor", 32'hFF00_FF00, 2'b10);
        run(5'b01110, 32'd0, 32'h1234_5678);        expect_out("not", 32'hFFFF_FFFF, 2'b10);
        run(5'b11111, 32'd2, 32'd3);                expect_out("undef_add", 32'd5, 2'b00);

        run(5'b00010, 32'd1, 32'd1);                expect_out("b2b_add", 32'd2, 2'b00);
        run(5'b00100, 32'd1, 32'd1);                expect_out("b2b_sub", 32'd0, 2'b01);
        run(5'b01100, 32'd4, 32'd2);                expect_out("b2b_or", 32'd6, 2'b00);

        rst = 1'b1;
        run(5'b00110, 32'd6, 32'd7);                expect_out("mid_reset", 32'd0, 2'b00);
        rst = 1'b0;
        run(5'b00110, 32'd6, 32'd7);                expect_out("after_mid_reset", 32'd42, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
